// File: rtl/rv32i_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rv32i_mem_arbiter_if                                           |
// | Purpose : Bundles the fetch port, load/store port, memory port and       |
// |           status signals of the unified-memory arbiter.                  |
// | Ports   : if_*  instruction fetch requester                              |
// |           d_*   load/store requester                                     |
// |           mem_* single-port fixed-latency memory                         |
// |           busy, stall_if  status                                         |
// |           slave  = arbiter side, master = requesters + memory side       |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface rv32i_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          stall_if;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, stall_if
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, stall_if
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rv32i_mem_arbiter                                              |
// | Purpose : Shares one single-port unified memory between the IF-stage     |
// |           fetch port and the MEM-stage load/store port. One access at a  |
// |           time, data has priority, a starvation guard forces a fetch     |
// |           after STARVE_MAX consecutive data grants with fetch pending.   |
// | Ports   : clk1   clock, all logic on posedge                             |
// |           rst_n  synchronous active-low reset                            |
// |           bus    rv32i_mem_arbiter_if.slave (fetch, data, memory,        |
// |                  busy, stall_if)                                         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rv32i_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  wire logic             clk1,
  input  wire logic             rst_n,
  rv32i_mem_arbiter_if.slave    bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_d_q;     // 1 = current access belongs to the data port
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q;
  logic          if_rvalid_q, d_rvalid_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  // Arbitration: data wins unless fetch has been starved long enough.
  logic w_force_if, w_pick_d, w_pick_if, w_last;
  assign w_force_if = bus.if_req & (starve_q == SW'(STARVE_MAX));
  assign w_pick_d   = bus.d_req & ~w_force_if;
  assign w_pick_if  = ~w_pick_d & bus.if_req;
  assign w_last     = (cnt_q == '0);

  // ---------------- state register ----------------
  always_ff @(posedge clk1) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.d_req | bus.if_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   if (w_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (w_pick_d) begin
            owner_d_q <= 1'b1;
            we_q      <= bus.d_we;
            addr_q    <= bus.d_addr;
            wdata_q   <= bus.d_wdata;
          end else if (w_pick_if) begin
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= bus.if_addr;
          end
        end
        S_ACCESS: cnt_q <= CW'(MEM_LAT - 1);
        S_WAIT: begin
          if (w_last) begin
            // rvalid is registered so it lands in the IDLE cycle after WAIT
            if (owner_d_q) begin
              d_rvalid_q <= 1'b1;
              if (!we_q) d_rdata_q <= bus.mem_rdata;
            end else begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase

      // Starve count only tracks grants made while fetch is actually waiting.
      if (!bus.if_req)
        starve_q <= '0;
      else if (state_q == S_IDLE && w_pick_if)
        starve_q <= '0;
      else if (state_q == S_IDLE && w_pick_d && starve_q != SW'(STARVE_MAX))
        starve_q <= starve_q + SW'(1);
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.mem_en    = (state_q == S_ACCESS);
    bus.mem_we    = (state_q == S_ACCESS) & we_q;
    bus.d_gnt     = (state_q == S_ACCESS) & owner_d_q;
    bus.if_gnt    = (state_q == S_ACCESS) & ~owner_d_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_rvalid = if_rvalid_q;
    bus.if_rdata  = if_rdata_q;
    bus.d_rvalid  = d_rvalid_q;
    bus.d_rdata   = d_rdata_q;
    bus.busy      = (state_q != S_IDLE);
    bus.stall_if  = bus.if_req & ~((state_q == S_ACCESS) & ~owner_d_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_rv32i_mem_arbiter                                           |
// | Purpose : Directed self-checking bench for rv32i_mem_arbiter. Instance A |
// |           uses MEM_LAT=1, instance B uses MEM_LAT=3; each has a small    |
// |           behavioural memory with the matching read latency.            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_rv32i_mem_arbiter;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  rv32i_mem_arbiter_if #(.AW(10), .DW(32)) ia ();
  rv32i_mem_arbiter_if #(.AW(10), .DW(32)) ib ();

  rv32i_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clk1(clk1), .rst_n(rst_n), .bus(ia));
  rv32i_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clk1(clk1), .rst_n(rst_n), .bus(ib));

  int checks = 0;
  int errors = 0;

  // Memory A: preset contents plus whatever has been stored; 1-cycle read.
  bit [31:0] memA [1024];
  bit        wflag [1024];
  logic [31:0] a_rd = '0;

  function automatic logic [31:0] romA(input logic [9:0] a);
    case (a)
      10'd5:   romA = 32'h0030_8133;
      10'd8:   romA = 32'h0231_00B3;
      default: romA = 32'h1000_0000 | {22'd0, a};
    endcase
  endfunction

  always @(posedge clk1) begin
    if (ia.mem_en) begin
      if (ia.mem_we) begin
        memA[ia.mem_addr]  <= ia.mem_wdata;
        wflag[ia.mem_addr] <= 1'b1;
      end else begin
        a_rd <= wflag[ia.mem_addr] ? memA[ia.mem_addr] : romA(ia.mem_addr);
      end
    end
  end
  assign ia.mem_rdata = a_rd;

  // Memory B: data = 0xA5A50000 | addr, 3-cycle read pipeline.
  logic [31:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;
  always @(posedge clk1) begin
    if (ib.mem_en && !ib.mem_we) b_p1 <= 32'hA5A5_0000 | {22'd0, ib.mem_addr};
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign ib.mem_rdata = b_p3;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic mid();
    @(negedge clk1);
  endtask

  task automatic test_reset();
    step(); step(); mid();
    checks++; if ({ia.busy, ia.mem_en, ia.mem_we, ia.if_gnt, ia.d_gnt, ia.if_rvalid, ia.d_rvalid, ia.stall_if} !== 8'h00) begin errors++; $display("FAIL reset_ctrl_a got=%b exp=00000000", {ia.busy, ia.mem_en, ia.mem_we, ia.if_gnt, ia.d_gnt, ia.if_rvalid, ia.d_rvalid, ia.stall_if}); end
    checks++; if ({ia.if_rdata, ia.d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata_a got=%h exp=0", {ia.if_rdata, ia.d_rdata}); end
    checks++; if ({ia.mem_addr, ia.mem_wdata} !== 42'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", {ia.mem_addr, ia.mem_wdata}); end
    checks++; if ({ib.busy, ib.mem_en, ib.if_rvalid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl_b got=%b exp=000", {ib.busy, ib.mem_en, ib.if_rvalid}); end
    step(); rst_n = 1'b1; mid();
  endtask

  task automatic test_fetch_single();
    step(); ia.if_req = 1'b1; ia.if_addr = 10'd5; mid();
    checks++; if ({ia.stall_if, ia.if_gnt} !== 2'b10) begin errors++; $display("FAIL t1_c0 stall/gnt got=%b exp=10", {ia.stall_if, ia.if_gnt}); end
    step(); mid();
    checks++; if ({ia.if_gnt, ia.mem_en, ia.mem_we, ia.stall_if} !== 4'b1100) begin errors++; $display("FAIL t1_c1 gnt/en/we/stall got=%b exp=1100", {ia.if_gnt, ia.mem_en, ia.mem_we, ia.stall_if}); end
    checks++; if (ia.mem_addr !== 10'd5) begin errors++; $display("FAIL t1_c1 mem_addr got=%0d exp=5", ia.mem_addr); end
    ia.if_req = 1'b0;
    step(); mid();
    checks++; if ({ia.if_rvalid, ia.busy} !== 2'b01) begin errors++; $display("FAIL t1_c2 rvalid/busy got=%b exp=01", {ia.if_rvalid, ia.busy}); end
    step(); mid();
    checks++; if ({ia.if_rvalid, ia.d_rvalid, ia.busy} !== 3'b100) begin errors++; $display("FAIL t1_c3 rvalid/busy got=%b exp=100", {ia.if_rvalid, ia.d_rvalid, ia.busy}); end
    checks++; if (ia.if_rdata !== 32'h0030_8133) begin errors++; $display("FAIL t1_c3 if_rdata got=%h exp=00308133", ia.if_rdata); end
    step(); mid();
    checks++; if ({ia.if_rvalid, ia.if_rdata} !== {1'b0, 32'h0030_8133}) begin errors++; $display("FAIL t1_c4 hold got=%b/%h exp=0/00308133", ia.if_rvalid, ia.if_rdata); end
  endtask

  task automatic test_contention();
    step();
    ia.if_req = 1'b1; ia.if_addr = 10'd0;
    ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 10'd8;
    mid();
    checks++; if (ia.stall_if !== 1'b1) begin errors++; $display("FAIL t2_c0 stall_if got=%b exp=1", ia.stall_if); end
    step(); mid();
    checks++; if ({ia.d_gnt, ia.if_gnt, ia.stall_if, ia.mem_addr} !== {3'b101, 10'd8}) begin errors++; $display("FAIL t2_c1 dgnt/ifgnt/stall/addr got=%b/%b/%b/%0d exp=1/0/1/8", ia.d_gnt, ia.if_gnt, ia.stall_if, ia.mem_addr); end
    ia.d_req = 1'b0;
    step(); mid();
    checks++; if (ia.stall_if !== 1'b1) begin errors++; $display("FAIL t2_c2 stall_if got=%b exp=1", ia.stall_if); end
    step(); mid();
    checks++; if ({ia.d_rvalid, ia.if_gnt, ia.stall_if} !== 3'b101) begin errors++; $display("FAIL t2_c3 drvalid/ifgnt/stall got=%b exp=101", {ia.d_rvalid, ia.if_gnt, ia.stall_if}); end
    checks++; if (ia.d_rdata !== 32'h0231_00B3) begin errors++; $display("FAIL t2_c3 d_rdata got=%h exp=023100b3", ia.d_rdata); end
    step(); mid();
    checks++; if ({ia.if_gnt, ia.stall_if, ia.mem_addr} !== {2'b10, 10'd0}) begin errors++; $display("FAIL t2_c4 ifgnt/stall/addr got=%b/%b/%0d exp=1/0/0", ia.if_gnt, ia.stall_if, ia.mem_addr); end
    ia.if_req = 1'b0;
    step(); mid();
    step(); mid();
    checks++; if ({ia.if_rvalid, ia.if_rdata} !== {1'b1, 32'h1000_0000}) begin errors++; $display("FAIL t2_c6 if_rvalid/rdata got=%b/%h exp=1/10000000", ia.if_rvalid, ia.if_rdata); end
  endtask

  task automatic test_starvation();
    logic [5:0] gseq;
    int  ng;
    bit  refire;
    gseq = '0; ng = 0; refire = 1'b0;
    step();
    ia.if_req = 1'b1; ia.if_addr = 10'h20;
    ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 10'h30;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin
        step();
        if (refire) begin ia.if_req = 1'b1; refire = 1'b0; end
      end
      mid();
      if (ia.d_gnt || ia.if_gnt) begin
        if (ng < 6) gseq[ng] = ia.d_gnt;
        ng++;
        if (ia.if_gnt) begin ia.if_req = 1'b0; refire = 1'b1; end
      end
    end
    checks++; if (ng !== 6) begin errors++; $display("FAIL t3_grant_count got=%0d exp=6", ng); end
    for (int g = 0; g < 6; g++) begin
      checks++; if (gseq[g] !== ((g == 4) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL t3_grant%0d data_owner got=%b exp=%b", g, gseq[g], (g == 4) ? 1'b0 : 1'b1); end
    end
    step(); ia.d_req = 1'b0; ia.if_req = 1'b0; mid();
    step(); mid();
    checks++; if ({ia.busy, ia.d_rdata} !== {1'b0, 32'h1000_0030}) begin errors++; $display("FAIL t3_end busy/d_rdata got=%b/%h exp=0/10000030", ia.busy, ia.d_rdata); end
  endtask

  task automatic test_store();
    step();
    ia.d_req = 1'b1; ia.d_we = 1'b1; ia.d_addr = 10'd10; ia.d_wdata = 32'hDEAD_BEEF;
    mid();
    checks++; if ({ia.d_gnt, ia.mem_en} !== 2'b00) begin errors++; $display("FAIL t4_c0 gnt/en got=%b exp=00", {ia.d_gnt, ia.mem_en}); end
    step(); mid();
    checks++; if ({ia.d_gnt, ia.mem_en, ia.mem_we} !== 3'b111) begin errors++; $display("FAIL t4_c1 gnt/en/we got=%b exp=111", {ia.d_gnt, ia.mem_en, ia.mem_we}); end
    checks++; if ({ia.mem_addr, ia.mem_wdata} !== {10'd10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL t4_c1 addr/wdata got=%0d/%h exp=10/deadbeef", ia.mem_addr, ia.mem_wdata); end
    ia.d_req = 1'b0; ia.d_we = 1'b0;
    step(); mid();
    step(); mid();
    checks++; if ({ia.d_rvalid, ia.d_rdata} !== {1'b1, 32'h1000_0030}) begin errors++; $display("FAIL t4_c3 d_rvalid/d_rdata got=%b/%h exp=1/10000030", ia.d_rvalid, ia.d_rdata); end
    checks++; if (memA[10] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t4_mem_written got=%h exp=deadbeef", memA[10]); end
  endtask

  task automatic test_reset_abort();
    step();
    ia.d_req = 1'b1; ia.d_we = 1'b0; ia.d_addr = 10'd8; ia.d_wdata = 32'h0;
    mid();
    step(); mid();
    checks++; if (ia.d_gnt !== 1'b1) begin errors++; $display("FAIL t5_c1 d_gnt got=%b exp=1", ia.d_gnt); end
    ia.d_req = 1'b0;
    step(); rst_n = 1'b0; mid();
    checks++; if (ia.busy !== 1'b1) begin errors++; $display("FAIL t5_c2 busy got=%b exp=1", ia.busy); end
    step(); rst_n = 1'b1; mid();
    checks++; if ({ia.busy, ia.mem_en, ia.mem_we, ia.if_gnt, ia.d_gnt, ia.if_rvalid, ia.d_rvalid, ia.stall_if} !== 8'h00) begin errors++; $display("FAIL t5_c3 ctrl got=%b exp=00000000", {ia.busy, ia.mem_en, ia.mem_we, ia.if_gnt, ia.d_gnt, ia.if_rvalid, ia.d_rvalid, ia.stall_if}); end
    checks++; if ({ia.d_rdata, ia.if_rdata, ia.mem_addr, ia.mem_wdata} !== 106'h0) begin errors++; $display("FAIL t5_c3 data got=%h exp=0", {ia.d_rdata, ia.if_rdata, ia.mem_addr, ia.mem_wdata}); end
    step(); mid();
    checks++; if ({ia.d_rvalid, ia.busy} !== 2'b00) begin errors++; $display("FAIL t5_c4 d_rvalid/busy got=%b exp=00", {ia.d_rvalid, ia.busy}); end
  endtask

  task automatic test_latency3();
    step(); ib.if_req = 1'b1; ib.if_addr = 10'd7; mid();
    step(); mid();
    checks++; if ({ib.if_gnt, ib.mem_en, ib.mem_addr} !== {2'b11, 10'd7}) begin errors++; $display("FAIL t6_c1 gnt/en/addr got=%b/%b/%0d exp=1/1/7", ib.if_gnt, ib.mem_en, ib.mem_addr); end
    ib.if_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      step(); mid();
      checks++; if ({ib.if_rvalid, ib.busy} !== 2'b01) begin errors++; $display("FAIL t6_c%0d rvalid/busy got=%b exp=01", c, {ib.if_rvalid, ib.busy}); end
    end
    step(); ib.if_req = 1'b1; ib.if_addr = 10'd9; mid();
    checks++; if ({ib.if_rvalid, ib.busy, ib.if_rdata} !== {2'b10, 32'hA5A5_0007}) begin errors++; $display("FAIL t6_c5 rvalid/busy/rdata got=%b/%b/%h exp=1/0/a5a50007", ib.if_rvalid, ib.busy, ib.if_rdata); end
    step(); mid();
    checks++; if ({ib.if_gnt, ib.mem_addr} !== {1'b1, 10'd9}) begin errors++; $display("FAIL t6_c6 gnt/addr got=%b/%0d exp=1/9", ib.if_gnt, ib.mem_addr); end
    ib.if_req = 1'b0;
    for (int c = 7; c <= 10; c++) begin step(); mid(); end
    checks++; if ({ib.if_rvalid, ib.if_rdata} !== {1'b1, 32'hA5A5_0009}) begin errors++; $display("FAIL t6_c10 rvalid/rdata got=%b/%h exp=1/a5a50009", ib.if_rvalid, ib.if_rdata); end
  endtask

  initial begin
    ia.if_req = 1'b0; ia.if_addr = '0; ia.d_req = 1'b0; ia.d_we = 1'b0; ia.d_addr = '0; ia.d_wdata = '0;
    ib.if_req = 1'b0; ib.if_addr = '0; ib.d_req = 1'b0; ib.d_we = 1'b0; ib.d_addr = '0; ib.d_wdata = '0;
    test_reset();
    test_fetch_single();
    test_contention();
    test_starvation();
    test_store();
    test_reset_abort();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
